// File: rtl/reg_writeback.sv
// Writeback result queue: merges load-unit and ALU results into an in-order
// FIFO that drains one register-file write per cycle, with a two-port bypass.
module reg_writeback #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [4:0]                 mem_rd,
    input  logic [XLEN-1:0]            mem_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    output logic                       wen,
    output logic [4:0]                 wr_rd,
    output logic [XLEN-1:0]            wr_data,
    input  logic [4:0]                 byp_rs1,
    input  logic [4:0]                 byp_rs2,
    output logic                       byp_hit1,
    output logic [XLEN-1:0]            byp_data1,
    output logic                       byp_hit2,
    output logic [XLEN-1:0]            byp_data2,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          q_mem [DEPTH];
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [CW-1:0]   free_w;
    logic [CW-1:0]   alu_need;
    logic            mem_xfer, alu_xfer;
    logic            mem_push, alu_push, pop;
    logic [1:0]      num_push;
    logic [PW-1:0]   alu_wptr;

    // Space is judged from the registered count only, so a same-cycle pop
    // never lends room to an incoming transfer.
    assign free_w    = CW'(DEPTH) - count_q;
    assign mem_ready = rst_n & (free_w != '0);
    assign mem_xfer  = mem_valid & mem_ready;
    assign alu_need  = mem_xfer ? CW'(2) : CW'(1);
    assign alu_ready = rst_n & (free_w >= alu_need);
    assign alu_xfer  = alu_valid & alu_ready;

    // x0 writes complete the handshake but are dropped here.
    assign mem_push  = mem_xfer & (mem_rd != 5'd0);
    assign alu_push  = alu_xfer & (alu_rd != 5'd0);
    assign pop       = (count_q != '0);
    assign num_push  = {1'b0, mem_push} + {1'b0, alu_push};
    assign alu_wptr  = mem_push ? PW'(wptr_q + 1'b1) : wptr_q;

    assign count_d   = count_q + CW'(num_push) - CW'(pop);
    assign wptr_d    = wptr_q + PW'(num_push);
    assign rptr_d    = rptr_q + PW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: every read is qualified by count.
    always_ff @(posedge clk) begin
        if (mem_push) q_mem[wptr_q]   <= '{rd: mem_rd, data: mem_data};
        if (alu_push) q_mem[alu_wptr] <= '{rd: alu_rd, data: alu_data};
    end

    assign count   = count_q;
    assign wen     = pop;
    assign wr_rd   = pop ? q_mem[rptr_q].rd   : 5'd0;
    assign wr_data = pop ? q_mem[rptr_q].data : '0;

    // Walk oldest to youngest so the last match is the youngest value.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q) begin
                if (byp_rs1 != 5'd0 && q_mem[rptr_q + PW'(k)].rd == byp_rs1) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = q_mem[rptr_q + PW'(k)].data;
                end
                if (byp_rs2 != 5'd0 && q_mem[rptr_q + PW'(k)].rd == byp_rs2) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = q_mem[rptr_q + PW'(k)].data;
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: hand-computed expectations per step.
module tb_reg_writeback;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mem_valid, mem_ready, alu_valid, alu_ready;
    logic [4:0]      mem_rd, alu_rd, wr_rd, byp_rs1, byp_rs2;
    logic [XLEN-1:0] mem_data, alu_data, wr_data, byp_data1, byp_data2;
    logic            wen, byp_hit1, byp_hit2;
    logic [2:0]      count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .wen(wen), .wr_rd(wr_rd), .wr_data(wr_data),
        .byp_rs1(byp_rs1), .byp_rs2(byp_rs2),
        .byp_hit1(byp_hit1), .byp_data1(byp_data1),
        .byp_hit2(byp_hit2), .byp_data2(byp_data2),
        .count(count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle behaviour with both producers streaming for 6 cycles,
    // then draining: mem accepts every cycle, alu only while two slots free.
    int          e_cnt [10] = '{0, 2, 3, 3, 3, 3, 3, 2, 1, 0};
    logic        e_ar  [10] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    logic [4:0]  e_rd  [10] = '{0, 7, 9, 7, 9, 7, 7, 7, 7, 0};
    logic [63:0] e_dat [10] = '{64'h0, 64'h100, 64'h200, 64'h101, 64'h201,
                                64'h102, 64'h103, 64'h104, 64'h105, 64'h0};

    initial begin
        rst_n = 1'b0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        byp_rs1 = 5'd5; byp_rs2 = 5'd31;

        #12;
        chk("rst_count", count, 0);
        chk("rst_wen", wen, 0);
        chk("rst_wr_rd", wr_rd, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_hit1", byp_hit1, 0);

        #10 rst_n = 1'b1;
        #1;
        chk("rel_mem_ready", mem_ready, 1);
        chk("rel_alu_ready", alu_ready, 1);
        tick();

        // single ALU result
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h2A;
        #1 chk("t1_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        #1;
        chk("t1_wen", wen, 1);
        chk("t1_wr_rd", wr_rd, 5);
        chk("t1_wr_data", wr_data, 64'h2A);
        chk("t1_count", count, 1);
        chk("t1_hit1", byp_hit1, 1);
        chk("t1_data1", byp_data1, 64'h2A);
        chk("t1_miss2", byp_hit2, 0);
        tick();
        chk("t1_wen_off", wen, 0);
        chk("t1_wr_data_off", wr_data, 0);

        // same-cycle MEM and ALU to one rd: MEM is older
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'h11;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h22;
        byp_rs1 = 5'd3;
        #1;
        chk("t2_mem_ready", mem_ready, 1);
        chk("t2_alu_ready", alu_ready, 1);
        chk("t2_no_early_byp", byp_hit1, 0);
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        #1;
        chk("t2_count", count, 2);
        chk("t2_wr_rd0", wr_rd, 3);
        chk("t2_wr_data0", wr_data, 64'h11);
        chk("t2_hit1", byp_hit1, 1);
        chk("t2_data1_young", byp_data1, 64'h22);
        tick();
        chk("t2_wr_data1", wr_data, 64'h22);
        chk("t2_count1", count, 1);
        tick();
        chk("t2_drained", wen, 0);

        // rd=0 is accepted but dropped
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
        byp_rs1 = 5'd0;
        #1 chk("t3_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        #1;
        chk("t3_count", count, 0);
        chk("t3_wen", wen, 0);
        chk("t3_hit1", byp_hit1, 0);
        chk("t3_data1", byp_data1, 0);

        // both producers streaming; queue wraps twice
        mem_rd = 5'd7; alu_rd = 5'd9;
        for (int c = 0; c < 10; c++) begin
            mem_valid = (c < 6);
            alu_valid = (c < 6);
            mem_data  = 64'h100 + 64'(c);
            alu_data  = 64'h200 + 64'((c < 2) ? c : 2);
            #1;
            chk($sformatf("t4_count_c%0d", c), count, 64'(e_cnt[c]));
            chk($sformatf("t4_mem_ready_c%0d", c), mem_ready, 1);
            chk($sformatf("t4_alu_ready_c%0d", c), alu_ready, e_ar[c]);
            chk($sformatf("t4_wen_c%0d", c), wen, e_cnt[c] != 0);
            chk($sformatf("t4_wr_rd_c%0d", c), wr_rd, e_rd[c]);
            chk($sformatf("t4_wr_data_c%0d", c), wr_data, e_dat[c]);
            tick();
        end
        mem_valid = 1'b0; alu_valid = 1'b0;

        // fill three entries then reset mid-cycle
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'h44;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 64'h66;
        tick();
        mem_rd = 5'd8; mem_data = 64'h88;
        alu_rd = 5'd10; alu_data = 64'hAA;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        byp_rs1 = 5'd8; byp_rs2 = 5'd6;
        #1;
        chk("t5_count3", count, 3);
        chk("t5_head", wr_data, 64'h66);
        chk("t5_hit1", byp_hit1, 1);
        chk("t5_data1", byp_data1, 64'h88);
        chk("t5_hit2", byp_hit2, 1);
        chk("t5_data2", byp_data2, 64'h66);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_wen", wen, 0);
        chk("t5_rst_count", count, 0);
        chk("t5_rst_hit1", byp_hit1, 0);
        chk("t5_rst_hit2", byp_hit2, 0);
        chk("t5_rst_mem_ready", mem_ready, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("t5_post_wen0", wen, 0);
        chk("t5_post_count0", count, 0);
        tick();
        chk("t5_post_wen1", wen, 0);
        chk("t5_post_wr_data", wr_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
